// File: rtl/arc4_core.sv
// ----------------------------------------------------------------------------
// arc4_core -- parametrised ARC4 (RC4 / RC4-drop[N]) decryption engine.
//
// Owns a 256x8 S-box (s_mem, single port, 1-cycle synchronous read). A run
// initialises S, performs the key schedule, optionally discards DROP_N
// keystream bytes, and decrypts a length-prefixed ciphertext into plaintext
// memory.
//
// Parameters
//   KEY_BYTES  key length in bytes (1..16); key byte 0 is the most significant
//   DROP_N     keystream bytes discarded after the key schedule (0..1023)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         start request, sampled only while rdy=1
//   rdy        idle and able to accept en
//   key        key, latched on an accepted en
//   ct_addr    ciphertext memory address (data returns one cycle later)
//   ct_rddata  ciphertext read data
//   pt_addr    plaintext write address
//   pt_rddata  plaintext read data (unused, kept for port compatibility)
//   pt_wrdata  plaintext write data
//   pt_wren    plaintext write strobe, one cycle per byte
//
// Handshake: a run starts on any rising clock edge where en && rdy. rdy drops
// the following cycle and stays low until the final plaintext byte has been
// written; it returns high in the cycle after that write, and en may already
// be high in that cycle for a back-to-back run. en while rdy=0 is ignored.
// ----------------------------------------------------------------------------

// 256x8 single-port S-box storage. q reflects mem[addr] from the previous
// cycle; a write and a read to the same address return the old contents.
module s_mem (
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);
    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= data;
        end
        q <= mem[addr];
    end
endmodule

module arc4_core #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_RD_J,
        KSA_WR_I,
        KSA_WR_J,
        DROP,
        LEN_RD,
        LEN_WR,
        PRGA_RD_I,
        PRGA_RD_J,
        PRGA_WR_I,
        PRGA_WR_J,
        PRGA_RD_K,
        PRGA_XOR
    } state_t;

    state_t state;

    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;        // S[i] as read before the swap
    logic [7:0]             sj;        // S[j] as read before the swap
    logic [7:0]             k;         // message byte index, 1..L
    logic [7:0]             len;       // message length from ct[0]
    logic [3:0]             key_idx;   // i mod KEY_BYTES as a wrapping counter
    logic [9:0]             drop_cnt;
    logic                   dropping;  // PRGA steps belong to the drop phase

    logic [7:0] s_addr;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;

    logic [7:0] key_byte;
    logic [7:0] j_next;

    logic [7:0] unused_pt;
    assign unused_pt = pt_rddata;

    s_mem u_s_mem (
        .clk  (clk),
        .addr (s_addr),
        .data (s_data),
        .wren (s_wren),
        .q    (s_q)
    );

    // Key byte 0 sits in the top byte of the key vector.
    always_comb begin
        key_byte = 8'(key_q >> (8 * (KEY_BYTES - 1 - int'(key_idx))));
    end

    // j update: the key byte only contributes during the key schedule.
    always_comb begin
        j_next = j + s_q;
        if (state == KSA_RD_J) begin
            j_next = j_next + key_byte;
        end
    end

    // S-box port steering. Read states present an address and the next state
    // consumes s_q. The swap writes S[i] first and S[j] second, so i == j
    // writes the same old value twice and leaves S unchanged.
    always_comb begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
        case (state)
            INIT: begin
                s_addr = i;
                s_data = i;
                s_wren = 1'b1;
            end
            KSA_RD_I, PRGA_RD_I: begin
                s_addr = i;
            end
            KSA_RD_J, PRGA_RD_J: begin
                s_addr = j_next;
            end
            KSA_WR_I, PRGA_WR_I: begin
                s_addr = i;
                s_data = s_q;
                s_wren = 1'b1;
            end
            KSA_WR_J, PRGA_WR_J: begin
                s_addr = j;
                s_data = si;
                s_wren = 1'b1;
            end
            PRGA_RD_K: begin
                s_addr = si + sj;
            end
            default: begin
                s_addr = 8'h00;
            end
        endcase
    end

    // The pad byte only exists in s_q during PRGA_XOR, so the XOR is formed
    // there; in every other state the output shows the registered length,
    // which is what LEN_WR writes and is zero out of reset.
    always_comb begin
        if (state == PRGA_XOR) begin
            pt_wrdata = ct_rddata ^ s_q;
        end else begin
            pt_wrdata = len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy      <= 1'b1;
            pt_wren  <= 1'b0;
            pt_addr  <= 8'h00;
            ct_addr  <= 8'h00;
            key_q    <= '0;
            i        <= 8'h00;
            j        <= 8'h00;
            si       <= 8'h00;
            sj       <= 8'h00;
            k        <= 8'h00;
            len      <= 8'h00;
            key_idx  <= 4'h0;
            drop_cnt <= 10'd0;
            dropping <= 1'b0;
        end else begin
            pt_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        key_q    <= key;
                        rdy      <= 1'b0;
                        i        <= 8'h00;
                        ct_addr  <= 8'h00;   // held at 0 until LEN_RD reads ct[0]
                        drop_cnt <= 10'd0;
                        dropping <= 1'b0;
                        state    <= INIT;
                    end
                end

                INIT: begin
                    i <= i + 8'd1;           // wraps to 0 for the key schedule
                    if (i == 8'd255) begin
                        j       <= 8'h00;
                        key_idx <= 4'h0;
                        state   <= KSA_RD_I;
                    end
                end

                KSA_RD_I: state <= KSA_RD_J;

                KSA_RD_J: begin
                    si    <= s_q;
                    j     <= j_next;
                    state <= KSA_WR_I;
                end

                KSA_WR_I: begin
                    sj    <= s_q;
                    state <= KSA_WR_J;
                end

                KSA_WR_J: begin
                    if (i == 8'd255) begin
                        i <= 8'h00;
                        j <= 8'h00;
                        state <= (DROP_N == 0) ? LEN_RD : DROP;
                    end else begin
                        i <= i + 8'd1;
                        if (key_idx == 4'(KEY_BYTES - 1)) begin
                            key_idx <= 4'h0;
                        end else begin
                            key_idx <= key_idx + 4'd1;
                        end
                        state <= KSA_RD_I;
                    end
                end

                DROP: begin
                    if (drop_cnt == 10'(DROP_N)) begin
                        dropping <= 1'b0;
                        state    <= LEN_RD;
                    end else begin
                        drop_cnt <= drop_cnt + 10'd1;
                        dropping <= 1'b1;
                        i        <= i + 8'd1;
                        state    <= PRGA_RD_I;
                    end
                end

                // ct_addr has been 0 since the run started, so ct[0] is
                // already on ct_rddata here.
                LEN_RD: begin
                    len     <= ct_rddata;
                    pt_addr <= 8'h00;
                    pt_wren <= 1'b1;
                    state   <= LEN_WR;
                end

                LEN_WR: begin
                    if (len == 8'h00) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        i       <= i + 8'd1;
                        k       <= 8'd1;
                        ct_addr <= 8'd1;
                        state   <= PRGA_RD_I;
                    end
                end

                PRGA_RD_I: state <= PRGA_RD_J;

                PRGA_RD_J: begin
                    si    <= s_q;
                    j     <= j_next;
                    state <= PRGA_WR_I;
                end

                PRGA_WR_I: begin
                    sj    <= s_q;
                    state <= PRGA_WR_J;
                end

                PRGA_WR_J: begin
                    state <= dropping ? DROP : PRGA_RD_K;
                end

                PRGA_RD_K: begin
                    pt_addr <= k;
                    pt_wren <= 1'b1;
                    state   <= PRGA_XOR;
                end

                // k stops at L (at most 255), so the address never overflows.
                PRGA_XOR: begin
                    if (k == len) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        i       <= i + 8'd1;
                        k       <= k + 8'd1;
                        ct_addr <= k + 8'd1;
                        state   <= PRGA_RD_I;
                    end
                end

                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_core.sv
`timescale 1ns/1ps

module tb_arc4_core;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Three engines: [0] KEY_BYTES=3, [1] KEY_BYTES=4, [2] KEY_BYTES=5 drop256
    logic [2:0]   en;
    logic [2:0]   rdy;
    logic [2:0]   pt_wren;
    logic [127:0] key_sel   [3];
    logic [7:0]   ct_addr   [3];
    logic [7:0]   ct_rddata [3];
    logic [7:0]   pt_addr   [3];
    logic [7:0]   pt_rddata [3];
    logic [7:0]   pt_wrdata [3];
    logic [7:0]   ct_mem    [3][256];
    int           start_cyc [3];

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];

    int n_tests = 0;
    int n_fail  = 0;

    assign pt_rddata[0] = 8'h00;
    assign pt_rddata[1] = 8'h00;
    assign pt_rddata[2] = 8'h00;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) ct_rddata[d] <= ct_mem[d][ct_addr[d]];
    end

    arc4_core #(.KEY_BYTES(3), .DROP_N(0)) u_k3 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key_sel[0][23:0]),
        .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]), .pt_addr(pt_addr[0]),
        .pt_rddata(pt_rddata[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));

    arc4_core #(.KEY_BYTES(4), .DROP_N(0)) u_k4 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key_sel[1][31:0]),
        .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]), .pt_addr(pt_addr[1]),
        .pt_rddata(pt_rddata[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));

    arc4_core #(.KEY_BYTES(5), .DROP_N(256)) u_k5 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key_sel[2][39:0]),
        .ct_addr(ct_addr[2]), .ct_rddata(ct_rddata[2]), .pt_addr(pt_addr[2]),
        .pt_rddata(pt_rddata[2]), .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min_v);
        n_tests++;
        if (act < min_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required >= %0d", name, act, min_v);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------
    task automatic push_exp(input int d, input logic [7:0] a, input logic [7:0] v);
        case (d)
            0: exp_q0.push_back({a, v});
            1: exp_q1.push_back({a, v});
            default: exp_q2.push_back({a, v});
        endcase
    endtask

    task automatic pop_exp(input int d, output bit ok, output logic [15:0] e);
        ok = 1'b1;
        e  = 16'h0;
        case (d)
            0: if (exp_q0.size() > 0) e = exp_q0.pop_front(); else ok = 1'b0;
            1: if (exp_q1.size() > 0) e = exp_q1.pop_front(); else ok = 1'b0;
            default: if (exp_q2.size() > 0) e = exp_q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // Software RC4-drop[N] over the ciphertext already loaded for engine d.
    task automatic push_model(input int d, input logic [127:0] k, input int klen,
                              input int drop);
        int s[256];
        int kb[16];
        int i, j, t, len, pad;
        len = int'(ct_mem[d][0]);
        for (int b = 0; b < klen; b++) kb[b] = int'(8'(k >> (8 * (klen - 1 - b))));
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (i = 0; i < 256; i++) begin
            j = (j + s[i] + kb[i % klen]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        push_exp(d, 8'h00, 8'(len));
        i = 0;
        j = 0;
        for (int n = 0; n < drop + len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            pad = s[(s[i] + s[j]) % 256];
            if (n >= drop) push_exp(d, 8'(n - drop + 1), ct_mem[d][n - drop + 1] ^ 8'(pad));
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every plaintext write is popped against the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        bit          ok;
        logic [15:0] e;
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                if (pt_wren[d] === 1'b1) begin
                    pop_exp(d, ok, e);
                    if (!ok) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write dut%0d: got addr %02h data %02h, required no write",
                                 d, pt_addr[d], pt_wrdata[d]);
                    end else begin
                        check8($sformatf("pt_addr dut%0d", d), pt_addr[d], e[15:8]);
                        check8($sformatf("pt_data dut%0d addr %02h", d, e[15:8]), pt_wrdata[d], e[7:0]);
                        if (d == 2 && e[15:8] == 8'h00)
                            check_ge("first_write_after_drop dut2", cyc - start_cyc[2], 2500);
                    end
                    check_bit($sformatf("rdy_low_during_write dut%0d", d), rdy[d], 1'b0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_rdy(input int d, input string name);
        int t = 0;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_bit(name, rdy[d], 1'b1);
    endtask

    task automatic start_run(input int d, input logic [127:0] k);
        wait_rdy(d, $sformatf("rdy_before_start dut%0d", d));
        key_sel[d] = k;
        en[d] = 1'b1;
        @(posedge clk);
        #1;
        start_cyc[d] = cyc;
        en[d] = 1'b0;
        check_bit($sformatf("rdy_low_after_accept dut%0d", d), rdy[d], 1'b0);
    endtask

    task automatic wait_done(input int d, input string name);
        wait_rdy(d, {name, "_complete"});
        check_int({name, "_all_writes_seen"}, q_size(d), 0);
    endtask

    task automatic load_random_ct(input int d, input int len);
        ct_mem[d][0] = 8'(len);
        for (int n = 1; n < 256; n++) ct_mem[d][n] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_key_vector(output logic [127:0] k);
        byte unsigned v[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        string p = "Plaintext";
        ct_mem[0][0] = 8'd9;
        for (int n = 0; n < 9; n++) ct_mem[0][n + 1] = v[n];
        push_exp(0, 8'h00, 8'd9);
        for (int n = 0; n < 9; n++) push_exp(0, 8'(n + 1), p[n]);
        k = 128'h4B6579;
    endtask

    function automatic logic [127:0] rand_key(input int klen);
        logic [127:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        return k & ((128'h1 << (8 * klen)) - 128'h1);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [127:0] k1, k2, k3;
        int t;
        rst_n = 1'b0;
        en    = 3'b000;
        for (int d = 0; d < 3; d++) begin
            key_sel[d]   = '0;
            start_cyc[d] = 0;
            for (int n = 0; n < 256; n++) ct_mem[d][n] = 8'h00;
        end

        // Reset state
        #23;
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("reset_rdy dut%0d", d), rdy[d], 1'b1);
            check_bit($sformatf("reset_pt_wren dut%0d", d), pt_wren[d], 1'b0);
            check8($sformatf("reset_ct_addr dut%0d", d), ct_addr[d], 8'h00);
            check8($sformatf("reset_pt_addr dut%0d", d), pt_addr[d], 8'h00);
            check8($sformatf("reset_pt_wrdata dut%0d", d), pt_wrdata[d], 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // "Key" / "Plaintext"
        load_key_vector(k1);
        start_run(0, k1);
        wait_done(0, "key_plaintext");

        // "Wiki" / "pedia"
        ct_mem[1][0] = 8'd5;
        ct_mem[1][1] = 8'h10; ct_mem[1][2] = 8'h21; ct_mem[1][3] = 8'hBF;
        ct_mem[1][4] = 8'h04; ct_mem[1][5] = 8'h20;
        push_exp(1, 8'h00, 8'd5);
        push_exp(1, 8'd1, "p"); push_exp(1, 8'd2, "e"); push_exp(1, 8'd3, "d");
        push_exp(1, 8'd4, "i"); push_exp(1, 8'd5, "a");
        start_run(1, 128'h57696B69);
        wait_done(1, "wiki_pedia");

        // Empty message: exactly one write (addr 0, data 0)
        load_random_ct(0, 0);
        push_exp(0, 8'h00, 8'h00);
        start_run(0, rand_key(3));
        wait_done(0, "len_zero");
        repeat (10) @(negedge clk);
        check_bit("len_zero_stays_idle", rdy[0], 1'b1);

        // Asynchronous reset in the middle of the key schedule, then rerun
        load_key_vector(k1);
        exp_q0.delete();
        start_run(0, k1);
        repeat (656) @(posedge clk);
        #2;
        check_bit("busy_before_reset", rdy[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check_bit("async_reset_rdy", rdy[0], 1'b1);
        check_bit("async_reset_pt_wren", pt_wren[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load_key_vector(k1);
        start_run(0, k1);
        wait_done(0, "rerun_after_reset");

        // en held high across two runs; later key changes and a stray pulse
        load_random_ct(0, 12);
        k1 = rand_key(3);
        k2 = rand_key(3);
        k3 = rand_key(3);
        push_model(0, k1, 3, 0);
        push_model(0, k2, 3, 0);
        wait_rdy(0, "held_en_ready");
        key_sel[0] = k1;
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        check_bit("held_en_first_accept", rdy[0], 1'b0);
        key_sel[0] = k2;
        wait_rdy(0, "held_en_first_done");
        @(posedge clk);
        #1;
        check_bit("held_en_second_accept", rdy[0], 1'b0);
        key_sel[0] = k3;
        en[0] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        wait_done(0, "held_en_second");
        repeat (20) @(negedge clk);
        check_bit("no_run_from_stray_en", rdy[0], 1'b1);
        check_int("no_extra_writes", q_size(0), 0);

        // RC4-drop256, 5-byte random key, maximum length
        load_random_ct(2, 255);
        k1 = rand_key(5);
        push_model(2, k1, 5, 256);
        start_run(2, k1);
        wait_done(2, "drop256_len255");

        // Random runs on the 4-byte engine, including length 1
        for (int r = 0; r < 3; r++) begin
            t = (r == 0) ? 1 : $urandom_range(2, 254);
            load_random_ct(1, t);
            k1 = rand_key(4);
            push_model(1, k1, 4, 0);
            start_run(1, k1);
            wait_done(1, $sformatf("random_k4_run%0d", r));
        end

        // Maximum length on the 3-byte engine
        load_random_ct(0, 255);
        k1 = rand_key(3);
        push_model(0, k1, 3, 0);
        start_run(0, k1);
        wait_done(0, "random_k3_len255");

        for (int d = 0; d < 3; d++)
            check_int($sformatf("final_queue_empty dut%0d", d), q_size(d), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
